// File: rtl/star_score_tracker_pkg.sv
// Shared game definitions: star tracker FSM states, BCD limits and the default
// scoring/flash timing that the HUD and sound blocks also reuse.
package star_score_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_CLEAR = 2'd2
  } star_state_e;

  localparam logic [15:0] BCD_MAX                 = 16'h9999;
  localparam logic [15:0] DEFAULT_STAR_POINTS_BCD = 16'h0100;
  localparam int unsigned DEFAULT_FLASH_CYCLES    = 25000000;

endpackage

// File: rtl/star_score_tracker_bcd_add_sat.sv
// Combinational 4-digit BCD adder; a carry out of the top digit clamps the
// result to 9999 instead of wrapping.
module bcd_add_sat
  import star_score_tracker_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [4:0]  dsum [4];
  logic [4:0]  carry;
  logic [15:0] raw;

  always_comb begin
    dsum  = '{default: '0};
    carry = '0;
    raw   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dsum[i] = 5'(a_i[4*i +: 4]) + 5'(b_i[4*i +: 4]) + 5'(carry[i]);
      if (dsum[i] > 5'd9) begin
        raw[4*i +: 4] = 4'(dsum[i] + 5'd6);
        carry[i+1]    = 1'b1;
      end else begin
        raw[4*i +: 4] = dsum[i][3:0];
        carry[i+1]    = 1'b0;
      end
    end
    sum_o = carry[4] ? BCD_MAX : raw;
  end

endmodule

// File: rtl/star_score_tracker.sv
// Turns per-star touch pulses / enable falls into one award per star per level,
// keeping star count, BCD score, the HUD flash window and level-clear status.
module star_score_tracker
  import star_score_tracker_pkg::*;
#(
  parameter int unsigned NUM_STARS       = 3,
  parameter logic [15:0] STAR_POINTS_BCD = DEFAULT_STAR_POINTS_BCD,
  parameter int unsigned FLASH_CYCLES    = DEFAULT_FLASH_CYCLES
) (
  input  logic                 sys_clk,
  input  logic                 RST_N,
  input  logic [NUM_STARS-1:0] star_en,
  input  logic [NUM_STARS-1:0] touch_star,
  input  logic                 level_restart,
  output logic [3:0]           star_count,
  output logic [15:0]          score_bcd,
  output logic                 flash,
  output logic                 all_collected,
  output logic                 level_clear
);

  localparam int unsigned PW = $clog2(NUM_STARS + 1);
  localparam int unsigned TW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FLASH_CYCLES - 1);
  localparam logic [3:0]    FULL_COUNT = 4'(NUM_STARS);

  logic [NUM_STARS-1:0] en_prev_q, collected_q, collected_d, new_w;
  logic [PW-1:0]        pending_q, pending_d, new_cnt;
  logic [3:0]           count_q, count_d;
  logic [15:0]          score_q, score_d, score_inc;
  logic                 award;

  star_state_e          state_q;
  logic [TW-1:0]        timer_q;
  logic                 flash_q, all_q, clear_q;

  // A star counts once whether it reports a touch, an enable fall, or both.
  assign new_w = (touch_star | (en_prev_q & ~star_en)) & ~collected_q;
  assign award = (pending_q != '0);

  bcd_add_sat u_bcd_add (
    .a_i  (score_q),
    .b_i  (STAR_POINTS_BCD),
    .sum_o(score_inc)
  );

  always_comb begin
    new_cnt = '0;
    for (int unsigned i = 0; i < NUM_STARS; i++) begin
      new_cnt = new_cnt + PW'(new_w[i]);
    end
    collected_d = collected_q | new_w;
    pending_d   = pending_q + new_cnt - PW'(award);
    count_d     = award ? count_q + 4'd1 : count_q;
    score_d     = award ? score_inc : score_q;
    if (level_restart) begin
      collected_d = '0;
      pending_d   = '0;
      count_d     = '0;
      score_d     = score_q;
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      en_prev_q   <= '1;
      collected_q <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      score_q     <= '0;
    end else begin
      en_prev_q   <= star_en;
      collected_q <= collected_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      score_q     <= score_d;
    end
  end

  // An award while flashing restarts the window; with no award, pending is zero,
  // so timer expiry alone decides between CLEAR and IDLE.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      flash_q <= 1'b0;
      all_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      if (level_restart) begin
        state_q <= ST_IDLE;
        timer_q <= '0;
        flash_q <= 1'b0;
        all_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (award) begin
              state_q <= ST_FLASH;
              timer_q <= TIMER_LOAD;
              flash_q <= 1'b1;
            end
          end
          ST_FLASH: begin
            if (award) begin
              timer_q <= TIMER_LOAD;
            end else if (timer_q != '0) begin
              timer_q <= timer_q - TW'(1);
            end else begin
              flash_q <= 1'b0;
              if (count_q == FULL_COUNT) begin
                state_q <= ST_CLEAR;
                all_q   <= 1'b1;
                clear_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_CLEAR: state_q <= ST_CLEAR;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign star_count    = count_q;
  assign score_bcd     = score_q;
  assign flash         = flash_q;
  assign all_collected = all_q;
  assign level_clear   = clear_q;

endmodule

// File: tb/tb_star_score_tracker.sv
// Scoreboard bench: the driver queues one token per expected collection event,
// the monitor pops a token whenever the DUT presents an award and checks timing.
module tb_star_score_tracker;

  localparam int N  = 3;
  localparam int FC = 8;

  logic          sys_clk = 1'b0;
  logic          RST_N   = 1'b0;
  logic [N-1:0]  star_en    = '1;
  logic [N-1:0]  touch_star = '0;
  logic          level_restart = 1'b0;
  logic [3:0]    star_count;
  logic [15:0]   score_bcd;
  logic          flash, all_collected, level_clear;

  star_score_tracker #(
    .NUM_STARS      (N),
    .STAR_POINTS_BCD(16'h0100),
    .FLASH_CYCLES   (FC)
  ) dut (
    .sys_clk      (sys_clk),
    .RST_N        (RST_N),
    .star_en      (star_en),
    .touch_star   (touch_star),
    .level_restart(level_restart),
    .star_count   (star_count),
    .score_bcd    (score_bcd),
    .flash        (flash),
    .all_collected(all_collected),
    .level_clear  (level_clear)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Driver-side reference state: which stars were taken this level.
  int tokq[$];
  bit coll[N];
  bit prev_en[N];
  logic [N-1:0] en_cur = '1;

  // Monitor-side reference state: awards actually seen.
  int  mcount = 0, mscore = 0, last_award = 0, last_count = 0, tok, due;
  bit  have_award = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int next_due(input int t);
    if (have_award && last_award + 1 > t + 1) return last_award + 1;
    return t + 1;
  endfunction

  function automatic bit all_taken();
    for (int i = 0; i < N; i++) if (!coll[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge sys_clk) begin
    if (!RST_N) begin
      mcount = 0; mscore = 0; have_award = 0; last_count = 0;
    end else begin
      if (level_restart) begin
        mcount = 0; have_award = 0; last_count = 0;
      end else if (int'(star_count) != last_count) begin
        if (tokq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_award: actual count=%0d required count=%0d", star_count, last_count);
        end else begin
          tok = tokq.pop_front();
          chk("award_edge", cyc, next_due(tok));
          mcount++;
          mscore = (mscore + 100 > 9999) ? 9999 : mscore + 100;
          have_award = 1; last_award = cyc;
        end
        last_count = int'(star_count);
      end else if (tokq.size() != 0) begin
        due = next_due(tokq[0]);
        if (due <= cyc) begin
          checks++; failures++;
          $display("FAIL missed_award: actual count=%0d required count=%0d", star_count, mcount + 1);
          void'(tokq.pop_front());
          mcount++;
          mscore = (mscore + 100 > 9999) ? 9999 : mscore + 100;
          have_award = 1; last_award = cyc;
        end
      end
      chk("star_count", int'(star_count), mcount);
      chk("score_bcd", int'(score_bcd), to_bcd(mscore));
      chk("flash", int'(flash), int'(have_award && (cyc - last_award) < FC));
      chk("all_collected", int'(all_collected), int'(have_award && mcount == N && (cyc - last_award) >= FC));
      chk("level_clear", int'(level_clear), int'(have_award && mcount == N && (cyc - last_award) == FC));
    end
  end

  task automatic drive(input logic [N-1:0] t, input logic [N-1:0] e, input logic rs);
    @(negedge sys_clk); #1;
    touch_star = t; star_en = e; level_restart = rs;
    if (rs) begin
      tokq.delete();
      for (int i = 0; i < N; i++) coll[i] = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (!coll[i] && (t[i] || (prev_en[i] && !e[i]))) begin
          coll[i] = 1;
          tokq.push_back(cyc + 1);
        end
    end
    for (int i = 0; i < N; i++) prev_en[i] = e[i];
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, en_cur, 1'b0);
  endtask

  task automatic restart();
    en_cur = '1;
    drive(N'($urandom), '1, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, int'(star_count), 0);
    chk({tag, "_score"}, int'(score_bcd), 0);
    chk({tag, "_flash"}, int'(flash), 0);
    chk({tag, "_all"}, int'(all_collected), 0);
    chk({tag, "_clear"}, int'(level_clear), 0);
  endtask

  task automatic async_reset();
    @(negedge sys_clk); #3;
    RST_N = 1'b0; touch_star = '0; level_restart = 1'b0; en_cur = '1; star_en = '1;
    tokq.delete();
    for (int i = 0; i < N; i++) begin coll[i] = 0; prev_en[i] = 1; end
    #1 check_zero("async_rst");
    @(negedge sys_clk); #1;
    RST_N = 1'b1;
  endtask

  logic [N-1:0] t, e;
  int guard;

  initial begin
    for (int i = 0; i < N; i++) begin coll[i] = 0; prev_en[i] = 1; end
    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    #1 RST_N = 1'b1;

    // Single touch of star 0, then let the flash window expire.
    idle(6);
    drive(3'b001, en_cur, 1'b0);
    idle(FC + 4);
    chk("t1_count", int'(star_count), 1);
    chk("t1_flash_off", int'(flash), 0);

    // Star 1: enable fall and touch together, then a repeated touch.
    restart();
    en_cur = 3'b101;
    drive(3'b010, en_cur, 1'b0);
    idle(5);
    drive(3'b010, en_cur, 1'b0);
    idle(FC + 4);
    chk("t2_count", int'(star_count), 1);
    chk("t2_score", int'(score_bcd), 16'h0200);

    // All three stars in one cycle, then level clear.
    restart();
    drive(3'b111, en_cur, 1'b0);
    idle(FC + 6);
    chk("t3_count", int'(star_count), 3);
    chk("t3_all", int'(all_collected), 1);
    chk("t3_score", int'(score_bcd), 16'h0500);

    // Restart while two awards are still pending; re-collection counts again.
    restart();
    drive(3'b111, en_cur, 1'b0);
    idle(1);
    drive('0, en_cur, 1'b1);
    idle(1);
    chk("t4_count", int'(star_count), 0);
    chk("t4_flash", int'(flash), 0);
    chk("t4_score", int'(score_bcd), 16'h0600);
    drive(3'b100, en_cur, 1'b0);
    idle(FC + 4);
    chk("t4_recollect", int'(star_count), 1);

    // Randomised levels drive the score into saturation.
    for (int lvl = 0; lvl < 40; lvl++) begin
      restart();
      guard = 0;
      while (!all_taken()) begin
        t = '0; e = en_cur;
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(7) == 0) t[i] = 1'b1;
          if ($urandom_range(11) == 0) e[i] = 1'b0;
        end
        guard++;
        if (guard > 30) t = '1;
        if (guard <= 30 && $urandom_range(59) == 0) restart();
        else begin
          en_cur = e;
          drive(t, e, 1'b0);
        end
      end
      idle(FC + $urandom_range(4));
    end
    chk("saturated", int'(score_bcd), 16'h9999);

    // Asynchronous reset in the middle of a flash window.
    restart();
    drive(3'b011, en_cur, 1'b0);
    idle(2);
    async_reset();
    idle(10);
    chk("post_rst_count", int'(star_count), 0);
    chk("post_rst_score", int'(score_bcd), 0);

    idle(2);
    chk("queue_drained", tokq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/star_score_tracker.md
Name: star_score_tracker

Overview:
- Consumer side of the star collectible interface: each star block reports a touch pulse and its enable flag; this block turns those into collection events, exactly once per star per level.
- Maintains collected-star count and a 4-digit BCD score, drives a "star collected" flash window for the HUD, and flags level clear once every star is taken.
- Sits between the per-star collision blocks and the display/HUD logic.

Parameters:
- NUM_STARS, 3, number of star blocks feeding this tracker (1..15).
- STAR_POINTS_BCD, 16'h0100, BCD score added per collected star.
- FLASH_CYCLES, 25000000, length of the flash window in sys_clk cycles (0.5 s at 50 MHz); must be >= 1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- star_en  input  NUM_STARS  per-star enable (1 = star still present).
- touch_star  input  NUM_STARS  per-star touch pulse.
- level_restart  input  1  synchronous level restart, active high.
- star_count  output  4  stars awarded this level.
- score_bcd  output  16  cumulative score, 4 BCD digits.
- flash  output  1  high during the flash window.
- all_collected  output  1  high while in CLEAR.
- level_clear  output  1  one-cycle pulse on entry to CLEAR.

Behaviour:
- Reset (RST_N low, async): star_count=0, score_bcd=0, flash=0, all_collected=0, level_clear=0, collected mask=0, pending=0, timer=0, state=IDLE. en_prev resets to all ones.
- Event detect, per star i, each edge:
  - new[i] = (touch_star[i] | (en_prev[i] & ~star_en[i])) & ~collected[i].
  - A star reporting only a touch pulse, only an enable fall, or both, is counted once.
  - en_prev <= star_en every cycle.
  - collected[i] <= 1 on new[i].
- Pending queue:
  - pending (width clog2(NUM_STARS+1)) += popcount(new).
  - Award step: whenever pending>0, one award per cycle; pending decrements.
  - Simultaneous add and award in the same cycle: pending <= pending + popcount(new) - 1.
- Award:
  - star_count += 1.
  - score_bcd += STAR_POINTS_BCD as a BCD add with per-digit carry; saturates at 16'h9999 and never wraps.
  - timer loads FLASH_CYCLES-1.
- Latency: event sampled at edge k; the award (star_count, score_bcd, flash) is visible after edge k+1. N simultaneous events are awarded on edges k+1..k+N.
- FSM:
  - IDLE: flash=0. Goes to FLASH on an award.
  - FLASH: flash=1. Timer decrements each cycle it is not reloaded. When timer==0 and pending==0:
    - goes to CLEAR if star_count==NUM_STARS;
    - otherwise goes to IDLE.
    - A further award in FLASH reloads the timer and keeps the state.
  - CLEAR: all_collected=1. level_clear=1 only on the first cycle. Stays in CLEAR until level_restart. New events are impossible here because all stars are collected.
- level_restart (synchronous; highest priority, overrides same-cycle events and awards):
  - Clears collected, pending, star_count, timer, flash, and all_collected.
  - Sets state=IDLE and en_prev <= star_en, so a restart with stars disabled causes no false edge.
  - score_bcd is retained.
- Reset asserted mid-flash or mid-award: everything returns to reset values immediately; pending awards are discarded.
- star_count never exceeds NUM_STARS, because of the collected mask.

Decomposition:
- Shared game package holds:
  - FSM state encoding (IDLE, FLASH, CLEAR);
  - the BCD max constant 16'h9999;
  - the default STAR_POINTS_BCD and FLASH_CYCLES values, reused by the HUD and sound blocks.
- One sub-module is natural: bcd_add_sat. It is a combinational 4-digit BCD adder with saturation and is reusable by other scorers.

Test Plan:
- Reset, then star 0 touch pulse at edge 10 → star_count=1, score_bcd=16'h0100, flash=1 after edge 11; flash=0 after FLASH_CYCLES cycles (bench uses FLASH_CYCLES=8).
- Star 1: star_en falls and touch_star pulses on the same cycle, then touch repeats 5 cycles later → exactly one award (star_count=1, score 16'h0100).
- Stars 0, 1 and 2 collected in the same cycle (NUM_STARS=3) → awards on three consecutive edges, score 16'h0300. After the flash expires: all_collected=1, level_clear high for exactly 1 cycle.
- Preload score near the limit (via 99 collect/restart cycles plus 9 extra stars, or a forced value) → score saturates at 16'h9999 and does not wrap.
- level_restart during FLASH with pending=2 → next cycle star_count=0, flash=0, state IDLE, score unchanged; stars re-collected afterwards count again.
- RST_N pulsed low mid-flash → all outputs 0 asynchronously; no spurious award after release while star_en is all ones.
